// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle request strobes into level pulses with a
// guaranteed high time and low gap, queueing requests that arrive mid-pulse.
module pulse_stretcher #(
    parameter int unsigned WD       = 16,
    parameter int unsigned HIGH_CYC = 64000,
    parameter int unsigned LOW_CYC  = 64000,
    parameter int unsigned QW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    output logic          data_out,
    output logic          busy,
    output logic [QW-1:0] pending,
    output logic          overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [WD-1:0] HIGH_LAST = WD'(HIGH_CYC - 1);
    localparam logic [WD-1:0] LOW_LAST  = WD'(LOW_CYC - 1);
    localparam logic [QW-1:0] PEND_MAX  = {QW{1'b1}};

    state_t        state_q;
    state_t        state_d;
    logic [WD-1:0] cnt_q;
    logic [WD-1:0] cnt_d;
    logic          data_d;
    logic          busy_d;
    logic [QW-1:0] pend_d;
    logic          ovf_d;
    logic          req_c;
    logic          start_c;
    logic          inc_c;
    logic          dec_c;

    // State, phase counter and all outputs registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_out <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_out <= data_d;
            busy     <= busy_d;
            pending  <= pend_d;
            overflow <= ovf_d;
        end
    end

    // Next-state, queue accounting and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pending;
        ovf_d   = overflow;
        start_c = 1'b0;
        inc_c   = 1'b0;
        dec_c   = 1'b0;
        req_c   = pulse_in || (pending != '0);

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    start_c = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == LOW_LAST) begin
                    if (req_c) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_c) begin
            state_d = ST_HIGH;
        end

        // A start with an empty queue is served directly by pulse_in; otherwise
        // it consumes the oldest queued request and pulse_in joins the queue.
        if (start_c) begin
            dec_c = (pending != '0);
            inc_c = pulse_in && (pending != '0);
        end else begin
            inc_c = pulse_in && (state_q != ST_IDLE);
        end

        if (inc_c && !dec_c) begin
            if (pending == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pending + QW'(1);
            end
        end else if (dec_c && !inc_c) begin
            pend_d = pending - QW'(1);
        end

        // Counter restarts on every state entry, otherwise advances while active
        if ((state_d != state_q) || (state_d == ST_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WD'(1);
        end

        data_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher: scoreboard against a countdown reference model,
// plus a long-pulse instance checked against fixed cycle counts.
module tb_pulse_stretcher;

    localparam int unsigned WD   = 16;
    localparam int unsigned HC   = 4;
    localparam int unsigned LC   = 3;
    localparam int unsigned QW   = 2;
    localparam int          PMAX = (1 << QW) - 1;

    typedef struct {
        bit d;
        bit b;
        int p;
        bit o;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in;
    logic          data_out;
    logic          busy;
    logic [QW-1:0] pending;
    logic          overflow;

    logic          rst_l;
    logic          pulse_l;
    logic          data_out_l;
    logic          busy_l;
    logic [QW-1:0] pending_l;
    logic          overflow_l;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    int m_st;
    int m_left;
    int m_pend;
    bit m_ovf;

    always #5 clk = ~clk;

    pulse_stretcher #(.WD(WD), .HIGH_CYC(HC), .LOW_CYC(LC), .QW(QW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .data_out (data_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    pulse_stretcher #(.WD(16), .HIGH_CYC(65535), .LOW_CYC(1), .QW(QW)) u_dut_long (
        .clk      (clk),
        .rst      (rst_l),
        .pulse_in (pulse_l),
        .data_out (data_out_l),
        .busy     (busy_l),
        .pending  (pending_l),
        .overflow (overflow_l)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_left = 0;
        m_pend = 0;
        m_ovf  = 1'b0;
    endtask

    // Reference: tracks cycles remaining in the current phase (0 idle, 1 high, 2 gap)
    task automatic model_step(input bit pin);
        bit start;
        int old;
        start = 1'b0;
        old   = m_st;
        case (m_st)
            0: if (pin || m_pend > 0) start = 1'b1;
            1: begin
                if (m_left == 1) begin
                    m_st   = 2;
                    m_left = LC;
                end else begin
                    m_left--;
                end
            end
            default: begin
                if (m_left == 1) begin
                    if (pin || m_pend > 0) start = 1'b1;
                    else m_st = 0;
                end else begin
                    m_left--;
                end
            end
        endcase
        if (start) begin
            m_st   = 1;
            m_left = HC;
            if (m_pend > 0) m_pend = m_pend - 1 + int'(pin);
        end else if (pin && old != 0) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.d = (m_st == 1);
        e.b = (m_st != 0);
        e.p = m_pend;
        e.o = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        check_eq({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "_data_out"}, 32'(data_out), 32'(e.d));
            check_eq({tag, "_busy"},     32'(busy),     32'(e.b));
            check_eq({tag, "_pending"},  32'(pending),  e.p);
            check_eq({tag, "_overflow"}, 32'(overflow), 32'(e.o));
        end
    endtask

    // One clock of stimulus: drive on the falling edge, check just after the rising edge
    task automatic step(input bit pin, input string tag);
        @(negedge clk);
        pulse_in = pin;
        model_step(pin);
        push_model();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, tag);
    endtask

    initial begin
        int hi;
        int lo;
        bit found;

        rst     = 1'b1;
        pulse_in = 1'b0;
        rst_l   = 1'b1;
        pulse_l = 1'b0;
        model_reset();

        #12;
        push_model();
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request
        step(1'b1, "single");
        idle_steps(8, "single");

        // Second request arrives mid-pulse and is replayed after the gap
        step(1'b1, "two");
        step(1'b0, "two");
        step(1'b1, "two");
        idle_steps(14, "two");

        // Request on the final gap edge with nothing queued
        step(1'b1, "gap_edge");
        idle_steps(6, "gap_edge");
        step(1'b1, "gap_edge");
        idle_steps(8, "gap_edge");

        // Held request: queue saturates, overflow sets, three replays follow
        for (int i = 0; i < 6; i++) step(1'b1, "burst");
        idle_steps(32, "burst");

        // Async reset mid-HIGH with pending=2 and overflow set
        for (int i = 0; i < 5; i++) step(1'b1, "pre_rst");
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, "pre_rst");
            if (m_st == 1 && m_pend == 2 && m_left == 2 && m_ovf) found = 1'b1;
        end
        check_eq("pre_rst_reached", 32'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_model();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, "post_rst");
        idle_steps(8, "post_rst");

        // Long pulse: HIGH_CYC at the counter limit, LOW_CYC=1
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        pulse_l = 1'b1;
        @(posedge clk);
        #1;
        check_eq("long_start", 32'(data_out_l), 1);
        @(posedge clk);
        #1;
        pulse_l = 1'b0;
        check_eq("long_queued", 32'(pending_l), 1);
        hi = 2;
        found = 1'b0;
        for (int i = 0; i < 70000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (!data_out_l) found = 1'b1;
            else hi++;
        end
        check_eq("long_high_cycles", hi, 65535);
        lo = 1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (data_out_l) found = 1'b1;
            else lo++;
        end
        check_eq("long_low_cycles", lo, 1);
        check_eq("long_pending_drained", 32'(pending_l), 0);
        check_eq("long_overflow", 32'(overflow_l), 0);
        rst_l = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
